// File: rtl/adder_bist_pkg.sv
// Shared types and helpers for the adder self-test engine.
package adder_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int ERR_W_DEF = 8;

    // Number of distinct {a,b,cin} vectors for a given operand width.
    function automatic int vec_count(input int width);
        return 2 ** (2 * width + 1);
    endfunction

endpackage

// File: rtl/adder_bist_golden.sv
// Reference adder: full-width a + b + cin with the carry kept in the MSB.
module adder_bist_golden #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH:0]   sum
);

    assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/adder_bist.sv
// Exhaustive self-test engine: walks every {a,b,cin} vector through the adder
// and compares its sum/carry against a golden model.
module adder_bist
    import adder_bist_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int DUT_LATENCY = 0,
    parameter int ERR_W       = ERR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   dut_a,
    output logic [WIDTH-1:0]   dut_b,
    output logic               dut_cin,
    input  logic [WIDTH-1:0]   dut_sum,
    input  logic               dut_cout,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [2*WIDTH:0]   first_fail,
    output logic               fail_seen
);

    localparam int VW  = 2 * WIDTH + 1;
    localparam int WCW = (DUT_LATENCY > 1) ? $clog2(DUT_LATENCY) : 1;
    localparam logic [VW-1:0]    VEC_LAST  = VW'(vec_count(WIDTH) - 1);
    localparam logic [WCW-1:0]   WAIT_LOAD = WCW'((DUT_LATENCY > 0) ? DUT_LATENCY - 1 : 0);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    state_e             state_q, state_d;
    logic [VW-1:0]      vec_q, vec_d;
    logic [WCW-1:0]     wait_q, wait_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               cin_q, cin_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [VW-1:0]      ff_q, ff_d;
    logic               fs_q, fs_d;
    logic [WIDTH:0]     exp_sum;
    logic               mismatch;

    // The golden model sees the same registered operands the adder sees.
    adder_bist_golden #(.WIDTH(WIDTH)) u_golden (
        .a   (a_q),
        .b   (b_q),
        .cin (cin_q),
        .sum (exp_sum)
    );

    assign mismatch = (exp_sum != {dut_cout, dut_sum});

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        wait_d  = wait_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        err_d   = err_q;
        ff_d    = ff_q;
        fs_d    = fs_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    vec_d   = '0;
                    err_d   = '0;
                    ff_d    = '0;
                    fs_d    = 1'b0;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                a_d   = vec_q[2*WIDTH:WIDTH+1];
                b_d   = vec_q[WIDTH:1];
                cin_d = vec_q[0];
                if (DUT_LATENCY > 0) begin
                    wait_d  = WAIT_LOAD;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_WAIT: begin
                if (wait_q == '0) state_d = ST_CHECK;
                else              wait_d  = wait_q - 1'b1;
            end
            ST_CHECK: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) err_d = err_q + 1'b1;
                    if (!fs_q) begin
                        ff_d = vec_q;
                        fs_d = 1'b1;
                    end
                end
                // Explicit last-vector test keeps vec from ever wrapping.
                if (vec_q == VEC_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    state_d = ST_DRIVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            wait_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            err_q   <= '0;
            ff_q    <= '0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            wait_q  <= wait_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            fs_q    <= fs_d;
        end
    end

    assign dut_a      = a_q;
    assign dut_b      = b_q;
    assign dut_cin    = cin_q;
    assign busy       = (state_q == ST_DRIVE) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
    assign done       = (state_q == ST_DONE);
    assign pass       = done && (err_q == '0);
    assign err_count  = err_q;
    assign first_fail = ff_q;
    assign fail_seen  = fs_q;

endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: a 1-bit engine against a fault-injectable full adder
// and a 4-bit, 2-stage engine against an adder with an inverted sum.
module tb_adder_bist;

    typedef struct {
        int err;
        int ff;
        int pass;
        int fs;
        int cyc;
        int nvec;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cmp   = 0;
    int fails = 0;

    exp_t q1[$];
    exp_t q2[$];

    // Small engine: WIDTH=1, DUT_LATENCY=0
    logic       start1 = 1'b0;
    logic [0:0] a1, b1, sum1;
    logic       cin1, cout1, busy1, done1, pass1, fs1;
    logic [7:0] err1;
    logic [2:0] ff1;
    int         fault1 = 0;
    logic [1:0] r1;

    assign r1    = {1'b0, a1} + {1'b0, b1} + {1'b0, cin1};
    assign sum1  = (fault1 == 1) ? 1'b0 : r1[0];
    assign cout1 = (fault1 == 2) ? 1'b0 : r1[1];

    adder_bist #(.WIDTH(1), .DUT_LATENCY(0), .ERR_W(8)) u_small (
        .clk(clk), .rst(rst), .start(start1),
        .dut_a(a1), .dut_b(b1), .dut_cin(cin1),
        .dut_sum(sum1), .dut_cout(cout1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail(ff1), .fail_seen(fs1)
    );

    // Large engine: WIDTH=4, DUT_LATENCY=2, adder sum inverted
    logic       start2 = 1'b0;
    logic [3:0] a2, b2, sum2;
    logic       cin2, cout2, busy2, done2, pass2, fs2;
    logic [7:0] err2;
    logic [8:0] ff2;
    logic [4:0] p1, p2;

    always @(posedge clk) begin
        p1 <= {1'b0, a2} + {1'b0, b2} + {4'b0, cin2};
        p2 <= p1;
    end
    assign sum2  = ~p2[3:0];
    assign cout2 = p2[4];

    adder_bist #(.WIDTH(4), .DUT_LATENCY(2), .ERR_W(8)) u_big (
        .clk(clk), .rst(rst), .start(start2),
        .dut_a(a2), .dut_b(b2), .dut_cin(cin2),
        .dut_sum(sum2), .dut_cout(cout2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_fail(ff2), .fail_seen(fs2)
    );

    task automatic chk(input string nm, input int act, input int exp);
        cmp++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Small monitor: scoreboard pop on done rising, plus applied-vector order.
    logic done1_prev = 1'b0;
    int   bcnt1 = 0;
    int   log1[$];
    always @(negedge clk) begin
        exp_t e;
        int   v, nbad;
        if (rst) begin
            bcnt1 = 0;
            log1.delete();
        end else begin
            if (busy1) begin
                if (bcnt1 > 0) begin
                    v = {a1, b1, cin1};
                    if (log1.size() == 0 || log1[$] != v) log1.push_back(v);
                end
                bcnt1++;
            end
            if (done1 && !done1_prev) begin
                if (q1.size() == 0) begin
                    chk("small.unexpected_done", 1, 0);
                end else begin
                    e = q1.pop_front();
                    chk("small.err_count", err1, e.err);
                    chk("small.first_fail", ff1, e.ff);
                    chk("small.pass", pass1, e.pass);
                    chk("small.fail_seen", fs1, e.fs);
                    chk("small.busy_cycles", bcnt1, e.cyc);
                    nbad = (log1.size() > e.nvec) ? log1.size() - e.nvec : e.nvec - log1.size();
                    for (int i = 0; i < log1.size() && i < e.nvec; i++)
                        if (log1[i] != i) nbad++;
                    chk("small.vec_order_errors", nbad, 0);
                end
                bcnt1 = 0;
                log1.delete();
            end
        end
        done1_prev = done1;
    end

    // Large monitor
    logic done2_prev = 1'b0;
    int   bcnt2 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            bcnt2 = 0;
        end else begin
            if (busy2) bcnt2++;
            if (done2 && !done2_prev) begin
                if (q2.size() == 0) begin
                    chk("big.unexpected_done", 1, 0);
                end else begin
                    e = q2.pop_front();
                    chk("big.err_count", err2, e.err);
                    chk("big.first_fail", ff2, e.ff);
                    chk("big.pass", pass2, e.pass);
                    chk("big.fail_seen", fs2, e.fs);
                    chk("big.busy_cycles", bcnt2, e.cyc);
                end
                bcnt2 = 0;
            end
        end
        done2_prev = done2;
    end

    task automatic pulse1();
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
    endtask

    task automatic wait_done1(input int budget, input string nm);
        int n = 0;
        while (!done1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done1) chk({nm, ".timeout"}, 0, 1);
        @(negedge clk);
    endtask

    task automatic push1(input int err, input int ff, input int pass, input int fs);
        exp_t e;
        e.err = err; e.ff = ff; e.pass = pass; e.fs = fs; e.cyc = 16; e.nvec = 8;
        q1.push_back(e);
    endtask

    task automatic chk_small_zero(input string nm);
        chk({nm, ".vec"}, {a1, b1, cin1}, 0);
        chk({nm, ".busy"}, busy1, 0);
        chk({nm, ".done"}, done1, 0);
        chk({nm, ".pass"}, pass1, 0);
        chk({nm, ".err_count"}, err1, 0);
        chk({nm, ".first_fail"}, ff1, 0);
        chk({nm, ".fail_seen"}, fs1, 0);
    endtask

    initial begin
        exp_t e;
        int   n;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_small_zero("reset");
        chk("reset.big_outputs", {a2, b2, cin2, busy2, done2, pass2, err2, ff2, fs2}, 0);
        rst = 1'b0;

        // Correct adder
        fault1 = 0;
        push1(0, 0, 1, 0);
        pulse1();
        wait_done1(40, "run_ok");

        // Sum stuck at 0, restarted from DONE, with a stray start mid-run
        fault1 = 1;
        push1(4, 1, 0, 1);
        pulse1();
        repeat (5) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        wait_done1(40, "run_sum0");

        // Carry-out stuck at 0, run twice for identical results
        fault1 = 2;
        push1(4, 3, 0, 1);
        pulse1();
        wait_done1(40, "run_cout0");
        push1(4, 3, 0, 1);
        pulse1();
        wait_done1(40, "run_cout0_again");

        // Reset while vector 5 is applied discards the partial run
        pulse1();
        n = 0;
        while ({a1, b1, cin1} != 3'd5 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid.reached_vec5", {a1, b1, cin1}, 5);
        rst = 1'b1;
        @(negedge clk);
        chk_small_zero("rst_mid");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_mid.stays_idle_busy", busy1, 0);
        chk("rst_mid.stays_idle_done", done1, 0);

        // start coincident with rst
        rst = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start1 = 1'b0;
        @(negedge clk);
        chk("rst_start.busy", busy1, 0);

        // Every vector mismatches: counter saturates, first failure is vector 0
        e.err = 255; e.ff = 0; e.pass = 0; e.fs = 1; e.cyc = 512 * 4; e.nvec = 512;
        q2.push_back(e);
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        n = 0;
        while (!done2 && n < 2200) begin
            @(negedge clk);
            n++;
        end
        if (!done2) chk("big.timeout", 0, 1);
        repeat (3) @(negedge clk);

        chk("small.scoreboard_left", q1.size(), 0);
        chk("big.scoreboard_left", q2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
        $finish;
    end

endmodule
